// File: rtl/port_arbiter.sv
// Four-port packet arbiter: round-robin grant per packet (header word carries payload count),
// FWFT FIFO heads muxed to one stream. Optional starvation abort under macro ARB_STALL_TIMEOUT_EN.
module port_arbiter #(
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic [3:0]         in_empty,
    input  logic [4*WIDTH-1:0] in_data,
    output logic [3:0]         in_pop,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_sop,
    output logic               out_eop,
    output logic [3:0]         grant,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HDR  = 2'd1,
        BODY = 2'd2
    } state_t;

    state_t     state_reg, state_next;
    logic [3:0] grant_reg, grant_next;
    logic [1:0] sel_reg, sel_next;
    logic [1:0] rr_ptr_reg, rr_ptr_next;
    logic [7:0] remaining_reg, remaining_next;

    logic [WIDTH-1:0] port_word [4];
    logic [3:0]       req_rot;
    logic             pick_valid;
    logic [1:0]       pick_off;
    logic [1:0]       pick_port;

    logic             busy;
    logic [WIDTH-1:0] head_word;
    logic [7:0]       head_len;
    logic             head_present;
    logic             transfer;
    logic             last_word;
    logic             abort;

    // req_rot[k] is the request of the port k+1 positions after the pointer, so the
    // lowest set bit is the next port in round-robin order.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_port
            localparam logic [1:0] OFFSET = 2'(gi + 1);
            assign port_word[gi] = in_data[gi*WIDTH +: WIDTH];
            assign req_rot[gi]   = !in_empty[rr_ptr_reg + OFFSET];
        end
    endgenerate

    always_comb begin
        pick_off = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            if (req_rot[k]) pick_off = 2'(k);
        end
        pick_valid = |req_rot;
        pick_port  = rr_ptr_reg + pick_off + 2'd1;
    end

    assign busy         = (state_reg != IDLE);
    assign head_word    = port_word[sel_reg];
    assign head_len     = head_word[7:0];
    assign head_present = !in_empty[sel_reg];

    assign out_valid = busy && head_present;
    assign transfer  = out_valid && out_ready;
    assign in_pop    = transfer ? grant_reg : 4'b0000;
    assign out_data  = busy ? head_word : '0;
    assign out_sop   = (state_reg == HDR) && out_valid;
    assign last_word = ((state_reg == HDR)  && (head_len == 8'd0)) ||
                       ((state_reg == BODY) && (remaining_reg == 8'd1));
    assign out_eop   = out_valid && last_word;
    assign grant     = grant_reg;

`ifdef ARB_STALL_TIMEOUT_EN
    logic [15:0] stall_reg, stall_next;

    // The current cycle counts as a stall cycle, hence the +1 before comparing.
    assign abort       = busy && !head_present && (({1'b0, stall_reg} + 17'd1) == 17'(TIMEOUT));
    assign timeout_err = abort;

    always_comb begin
        stall_next = stall_reg;
        if (!busy || head_present || abort) begin
            stall_next = 16'd0;
        end else begin
            stall_next = stall_reg + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_reg <= 16'd0;
        end else begin
            stall_reg <= stall_next;
        end
    end
`else
    assign abort       = 1'b0;
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_next     = state_reg;
        grant_next     = grant_reg;
        sel_next       = sel_reg;
        rr_ptr_next    = rr_ptr_reg;
        remaining_next = remaining_reg;
        case (state_reg)
            IDLE: begin
                if (pick_valid) begin
                    state_next  = HDR;
                    grant_next  = 4'b0001 << pick_port;
                    sel_next    = pick_port;
                    rr_ptr_next = pick_port;
                end
            end
            HDR: begin
                if (transfer) begin
                    remaining_next = head_len;
                    if (head_len == 8'd0) begin
                        state_next = IDLE;
                        grant_next = 4'b0000;
                    end else begin
                        state_next = BODY;
                    end
                end
            end
            BODY: begin
                if (transfer) begin
                    remaining_next = remaining_reg - 8'd1;
                    if (remaining_reg == 8'd1) begin
                        state_next = IDLE;
                        grant_next = 4'b0000;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = 4'b0000;
            end
        endcase
        // A starved grant is dropped; the abort only fires while nothing transfers.
        if (abort) begin
            state_next     = IDLE;
            grant_next     = 4'b0000;
            remaining_next = 8'd0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= IDLE;
            grant_reg     <= 4'b0000;
            sel_reg       <= 2'd0;
            rr_ptr_reg    <= 2'd3;
            remaining_reg <= 8'd0;
        end else begin
            state_reg     <= state_next;
            grant_reg     <= grant_next;
            sel_reg       <= sel_next;
            rr_ptr_reg    <= rr_ptr_next;
            remaining_reg <= remaining_next;
        end
    end

endmodule

// File: tb/tb_port_arbiter.sv
// Directed bench for port_arbiter: a cycle table for arbitration/framing, plus hand sequences
// for a long starvation stall and reset asserted mid-packet.
module tb_port_arbiter;
    localparam int W  = 16;
    localparam int TO = 8;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [3:0]     in_empty = 4'b0000;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_pop;
    logic [W-1:0]   out_data;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic           out_sop;
    logic           out_eop;
    logic [3:0]     grant;
    logic           timeout_err;

    int errors = 0;
    int checks = 0;

    port_arbiter #(.WIDTH(W), .TIMEOUT(TO)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .in_empty    (in_empty),
        .in_data     (in_data),
        .in_pop      (in_pop),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sop     (out_sop),
        .out_eop     (out_eop),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]   empty;
        logic [W-1:0] w0, w1, w2, w3;
        logic         ready;
        logic [3:0]   grant;
        logic [3:0]   pop;
        logic         valid;
        logic         sop;
        logic         eop;
        logic [W-1:0] data;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic [3:0] e, logic [W-1:0] w0, logic [W-1:0] w1,
                                logic [W-1:0] w2, logic [W-1:0] w3, logic rdy,
                                logic [3:0] g, logic [3:0] p, logic v, logic s,
                                logic eo, logic [W-1:0] d);
        vec_t r;
        r.empty = e;  r.w0 = w0; r.w1 = w1; r.w2 = w2; r.w3 = w3; r.ready = rdy;
        r.grant = g;  r.pop = p; r.valid = v; r.sop = s; r.eop = eo; r.data = d;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] e, input logic [W-1:0] w0, input logic [W-1:0] w1,
                         input logic [W-1:0] w2, input logic [W-1:0] w3, input logic rdy);
        in_empty  = e;
        in_data   = {w3, w2, w1, w0};
        out_ready = rdy;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [3:0] p,
                              input logic v, input logic s, input logic eo, input logic to);
        check({tag, ".grant"},       32'(grant),       32'(g));
        check({tag, ".in_pop"},      32'(in_pop),      32'(p));
        check({tag, ".out_valid"},   32'(out_valid),   32'(v));
        check({tag, ".out_sop"},     32'(out_sop),     32'(s));
        check({tag, ".out_eop"},     32'(out_eop),     32'(eo));
        check({tag, ".timeout_err"}, 32'(timeout_err), 32'(to));
    endtask

    initial begin
        // all four ports hold single-word packets, round-robin from port 0
        tbl.push_back(mk(4'b0000, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b0000, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0001, 4'b0001, 1, 1, 1, 16'hA000));
        tbl.push_back(mk(4'b0001, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b0001, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0010, 4'b0010, 1, 1, 1, 16'hA100));
        tbl.push_back(mk(4'b0011, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b0011, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0100, 4'b0100, 1, 1, 1, 16'hA200));
        tbl.push_back(mk(4'b0111, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b0111, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1, 4'b1000, 4'b1000, 1, 1, 1, 16'hA300));
        tbl.push_back(mk(4'b1111, 16'h0,    16'h0,    16'h0,    16'h0,    1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        // port 0, N=2: three consecutive transfers (pointer wrapped 3 -> 0)
        tbl.push_back(mk(4'b1110, 16'h1002, 16'h0, 16'h0, 16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b1110, 16'h1002, 16'h0, 16'h0, 16'h0, 1, 4'b0001, 4'b0001, 1, 1, 0, 16'h1002));
        tbl.push_back(mk(4'b1110, 16'h2001, 16'h0, 16'h0, 16'h0, 1, 4'b0001, 4'b0001, 1, 0, 0, 16'h2001));
        tbl.push_back(mk(4'b1110, 16'h2002, 16'h0, 16'h0, 16'h0, 1, 4'b0001, 4'b0001, 1, 0, 1, 16'h2002));
        tbl.push_back(mk(4'b1111, 16'h0,    16'h0, 16'h0, 16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        // port 1, N=2 with out_ready toggling in BODY
        tbl.push_back(mk(4'b1101, 16'h0, 16'h1102, 16'h0, 16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b1101, 16'h0, 16'h1102, 16'h0, 16'h0, 1, 4'b0010, 4'b0010, 1, 1, 0, 16'h1102));
        tbl.push_back(mk(4'b1101, 16'h0, 16'h2101, 16'h0, 16'h0, 0, 4'b0010, 4'b0000, 1, 0, 0, 16'h2101));
        tbl.push_back(mk(4'b1101, 16'h0, 16'h2101, 16'h0, 16'h0, 1, 4'b0010, 4'b0010, 1, 0, 0, 16'h2101));
        tbl.push_back(mk(4'b1101, 16'h0, 16'h2102, 16'h0, 16'h0, 0, 4'b0010, 4'b0000, 1, 0, 1, 16'h2102));
        tbl.push_back(mk(4'b1101, 16'h0, 16'h2102, 16'h0, 16'h0, 1, 4'b0010, 4'b0010, 1, 0, 1, 16'h2102));
        tbl.push_back(mk(4'b1111, 16'h0, 16'h0,    16'h0, 16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        // port 2 N=3 holds grant while port 0 waits; then 3 empty so port 0 next
        tbl.push_back(mk(4'b1010, 16'h1000, 16'h0, 16'h1203, 16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b1010, 16'h1000, 16'h0, 16'h1203, 16'h0, 1, 4'b0100, 4'b0100, 1, 1, 0, 16'h1203));
        tbl.push_back(mk(4'b1010, 16'h1000, 16'h0, 16'h2201, 16'h0, 1, 4'b0100, 4'b0100, 1, 0, 0, 16'h2201));
        tbl.push_back(mk(4'b1010, 16'h1000, 16'h0, 16'h2202, 16'h0, 1, 4'b0100, 4'b0100, 1, 0, 0, 16'h2202));
        tbl.push_back(mk(4'b1010, 16'h1000, 16'h0, 16'h2203, 16'h0, 1, 4'b0100, 4'b0100, 1, 0, 1, 16'h2203));
        tbl.push_back(mk(4'b1110, 16'h1000, 16'h0, 16'h0,    16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));
        tbl.push_back(mk(4'b1110, 16'h1000, 16'h0, 16'h0,    16'h0, 1, 4'b0001, 4'b0001, 1, 1, 1, 16'h1000));
        tbl.push_back(mk(4'b1111, 16'h0,    16'h0, 16'h0,    16'h0, 1, 4'b0000, 4'b0000, 0, 0, 0, 16'h0));

        // reset held with all ports non-empty: nothing may be granted or popped
        drive(4'b0000, 16'hA000, 16'hA100, 16'hA200, 16'hA300, 1);
        @(negedge clock);
        #1;
        check_outs("reset", 4'b0000, 4'b0000, 0, 0, 0, 0);
        in_empty = 4'b1111;
        reset_n  = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            drive(tbl[i].empty, tbl[i].w0, tbl[i].w1, tbl[i].w2, tbl[i].w3, tbl[i].ready);
            #1;
            check_outs($sformatf("vec%0d", i), tbl[i].grant, tbl[i].pop, tbl[i].valid,
                       tbl[i].sop, tbl[i].eop, 1'b0);
            if (tbl[i].valid) check($sformatf("vec%0d.out_data", i), 32'(out_data), 32'(tbl[i].data));
            $display("vec %0d: empty=%b ready=%b grant=%b pop=%b valid=%b sop=%b eop=%b data=%h",
                     i, in_empty, out_ready, grant, in_pop, out_valid, out_sop, out_eop, out_data);
        end

        // port 1 granted, then its FIFO runs dry in HDR for longer than TIMEOUT
        @(negedge clock);
        drive(4'b1101, 16'h0, 16'h1101, 16'h0, 16'h0, 1);
        #1;
        check_outs("stall.idle", 4'b0000, 4'b0000, 0, 0, 0, 0);
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            drive(4'b1111, 16'h0, 16'h1101, 16'h0, 16'h0, 1);
            #1;
`ifdef ARB_STALL_TIMEOUT_EN
            check_outs($sformatf("stall%0d", k), (k <= TO) ? 4'b0010 : 4'b0000, 4'b0000, 0, 0, 0,
                       (k == TO) ? 1'b1 : 1'b0);
`else
            check_outs($sformatf("stall%0d", k), 4'b0010, 4'b0000, 0, 0, 0, 0);
`endif
            $display("stall %0d: grant=%b timeout_err=%b", k, grant, timeout_err);
        end

        // fresh reset, then port 3 packet interrupted by reset in BODY
        @(negedge clock);
        reset_n = 1'b0;
        drive(4'b1111, 16'h0, 16'h0, 16'h0, 16'h0, 1);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        drive(4'b0111, 16'h0, 16'h0, 16'h0, 16'h1302, 1);
        #1;
        check_outs("p3.idle", 4'b0000, 4'b0000, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        check_outs("p3.hdr", 4'b1000, 4'b1000, 1, 1, 0, 0);
        check("p3.hdr.out_data", 32'(out_data), 32'h1302);
        @(negedge clock);
        drive(4'b0111, 16'h0, 16'h0, 16'h0, 16'h2301, 1);
        #1;
        check_outs("p3.body", 4'b1000, 4'b1000, 1, 0, 0, 0);
        @(negedge clock);
        drive(4'b0110, 16'h1000, 16'h0, 16'h0, 16'h2302, 1);
        reset_n = 1'b0;
        #1;
        check_outs("p3.reset", 4'b0000, 4'b0000, 0, 0, 0, 0);
        $display("reset mid-body: grant=%b pop=%b valid=%b", grant, in_pop, out_valid);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        check_outs("post_reset.idle", 4'b0000, 4'b0000, 0, 0, 0, 0);
        @(negedge clock);
        #1;
        check_outs("post_reset.p0", 4'b0001, 4'b0001, 1, 1, 1, 0);
        check("post_reset.out_data", 32'(out_data), 32'h1000);
        $display("post reset: grant=%b pop=%b data=%h", grant, in_pop, out_data);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
